// File: rtl/knob_pkg.sv
// knob_pkg: channel encodings and select-state types shared by knob_ctrl and the colour/PWM logic
package knob_pkg;
    typedef logic [1:0] ch_t;
    localparam ch_t CH_R = 2'd0;
    localparam ch_t CH_G = 2'd1;
    localparam ch_t CH_B = 2'd2;
    typedef enum logic [1:0] {SEL_R = CH_R, SEL_G = CH_G, SEL_B = CH_B} sel_state_t;
endpackage

// File: rtl/knob_ctrl_debounce.sv
// debounce: 2-FF synchroniser plus stability counter; rise pulses one cycle after the debounced level goes high
module debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, level_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            level <= 1'b0;
            level_q <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            cnt <= s2 != level && cnt != LAST ? cnt + 1'b1 : '0;
            level <= s2 != level && cnt == LAST ? s2 : level;
            level_q <= level;
            rise <= level & ~level_q;
        end
    end
endmodule

// File: rtl/knob_ctrl.sv
// knob_ctrl: debounced button cycles R/G/B selection, detents saturate-step the selected level.
// Define KNOB_ACCEL_EN to use ACCEL_STEP for quick same-direction detents.
module knob_ctrl
    import knob_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACCEL_WINDOW = 200000,
    parameter int ACCEL_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cw,
    input  logic             ccw,
    input  logic             btn,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] red,
    output logic [WIDTH-1:0] green,
    output logic [WIDTH-1:0] blue,
    output logic             changed
);
    localparam logic [WIDTH:0] BASE = (WIDTH + 1)'(STEP);
    sel_state_t state, state_d;
    logic btn_level, btn_rise, press, inc, dec;
    logic [WIDTH:0] step, sum, dif;
    logic [WIDTH-1:0] cur, nxt;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .level(btn_level),
        .rise(btn_rise)
    );

    assign press = btn_rise & btn_level;
    assign inc = cw & ~ccw;
    assign dec = ccw & ~cw;
    assign sel = ch_t'(state);

`ifdef KNOB_ACCEL_EN
    localparam int GW = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GW-1:0] GMAX = GW'(ACCEL_WINDOW);
    localparam logic [WIDTH:0] FAST = (WIDTH + 1)'(ACCEL_STEP);
    logic [GW-1:0] gap;
    logic last_cw, recent;
    // a saturated gap means no recent detent, so direction history is irrelevant
    assign recent = gap < GMAX;
    assign step = recent && last_cw == inc ? FAST : BASE;
    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= GMAX;
            last_cw <= 1'b0;
        end else begin
            gap <= press || ((inc | dec) && recent && last_cw != inc) ? GMAX :
                   (inc | dec) ? GW'(1) : recent ? gap + 1'b1 : gap;
            if (inc | dec) last_cw <= inc;
        end
    end
`else
    assign step = BASE;
`endif

    always_comb begin
        state_d = state;
        if (press) state_d = state == SEL_R ? SEL_G : state == SEL_G ? SEL_B : SEL_R;
        cur = state == SEL_G ? green : state == SEL_B ? blue : red;
        sum = {1'b0, cur} + step;
        dif = {1'b0, cur} - step;
        nxt = inc ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0]) :
              dec ? (dif[WIDTH] ? '0 : dif[WIDTH-1:0]) : cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEL_R;
            red <= '0;
            green <= '0;
            blue <= '0;
            changed <= 1'b0;
        end else begin
            state <= state_d;
            if (state == SEL_R) red <= nxt;
            if (state == SEL_G) green <= nxt;
            if (state == SEL_B) blue <= nxt;
            changed <= press || nxt != cur;
        end
    end
endmodule

// File: tb/tb_knob_ctrl.sv
// tb_knob_ctrl: directed scenarios plus random stimulus checked against a reference model
module tb_knob_ctrl;
    localparam int W = 8, STEP = 1, D = 4, AW = 10, AS = 8;
    localparam int MAXV = (1 << W) - 1;
    logic clk = 0, rst = 1, cw = 0, ccw = 0, btn = 0;
    logic [1:0] sel;
    logic [W-1:0] red, green, blue;
    logic changed;
    int errors = 0, checks = 0;

    knob_ctrl #(.WIDTH(W), .STEP(STEP), .DEBOUNCE_CYCLES(D), .ACCEL_WINDOW(AW), .ACCEL_STEP(AS)) dut (
        .clk(clk), .rst(rst), .cw(cw), .ccw(ccw), .btn(btn),
        .sel(sel), .red(red), .green(green), .blue(blue), .changed(changed)
    );

    always #5 clk = ~clk;

    int m_lv[3];
    int m_sel, m_last_t, m_cyc;
    bit m_chg, m_db, m_p1, m_p2, m_valid, m_last_cw;
    bit m_bh[$];
    always @(posedge clk) begin
        bit press, flip, recent;
        int step, cur, nv;
        m_cyc++;
        if (rst) begin
            m_lv = '{0, 0, 0};
            m_sel = 0; m_chg = 0; m_db = 0; m_p1 = 0; m_p2 = 0; m_valid = 0;
            m_bh = {};
            repeat (D + 2) m_bh.push_back(1'b0);
        end else begin
            press = m_p2; m_p2 = m_p1; m_p1 = 0;
            m_bh.push_back(btn);
            void'(m_bh.pop_front());
            flip = 1;
            for (int i = 0; i < D; i++) if (m_bh[i] == m_db) flip = 0;
            if (flip) begin m_db = !m_db; m_p1 = m_db; end
            step = STEP;
            if (cw != ccw) begin
                recent = m_valid && (m_cyc - m_last_t) < AW;
`ifdef KNOB_ACCEL_EN
                if (recent && m_last_cw == cw) step = AS;
`endif
                m_valid = !(recent && m_last_cw != cw);
                m_last_t = m_cyc;
                m_last_cw = cw;
            end
            if (press) m_valid = 0;
            cur = m_lv[m_sel];
            nv = cur;
            if (cw && !ccw) nv = (cur + step > MAXV) ? MAXV : cur + step;
            if (ccw && !cw) nv = (cur - step < 0) ? 0 : cur - step;
            m_chg = press || nv != cur;
            m_lv[m_sel] = nv;
            if (press) m_sel = (m_sel + 1) % 3;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic do_reset;
        rst = 1; cw = 0; ccw = 0; btn = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (red !== 0 || green !== 0 || blue !== 0) begin errors++; $display("FAIL reset_levels got %0d/%0d/%0d want 0/0/0", red, green, blue); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed); end
    endtask

    task automatic test_cw_steps;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            cw = 1; tick(); cw = 0;
            checks++; if (red !== W'(i) || changed !== 1'b1) begin errors++; $display("FAIL cw_step%0d got red=%0d changed=%b want red=%0d changed=1", i, red, changed, i); end
            tick();
            checks++; if (changed !== 1'b0) begin errors++; $display("FAIL cw_pulse_end%0d got changed=%b want 0", i, changed); end
            tick(18);
        end
        checks++; if (green !== 0 || blue !== 0) begin errors++; $display("FAIL cw_others got green=%0d blue=%0d want 0/0", green, blue); end
    endtask

    task automatic test_button;
        int bad = 0;
        do_reset();
        btn = 1; tick(3); btn = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (sel !== 0 || changed !== 0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL bounce got %0d bad cycles want 0", bad); end
        btn = 1;
        bad = 0;
        for (int i = 0; i < 7; i++) begin tick(); if (sel !== 0 || changed !== 0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL press_early got %0d bad cycles want 0", bad); end
        tick();
        checks++; if (sel !== 2'd1 || changed !== 1'b1) begin errors++; $display("FAIL press_edge got sel=%0d changed=%b want sel=1 changed=1", sel, changed); end
        tick();
        checks++; if (sel !== 2'd1 || changed !== 1'b0) begin errors++; $display("FAIL press_after got sel=%0d changed=%b want sel=1 changed=0", sel, changed); end
        btn = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (sel !== 1 || changed !== 0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL release got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_saturate;
        do_reset();
        ccw = 1; tick(); ccw = 0;
        checks++; if (red !== 0 || changed !== 1'b0) begin errors++; $display("FAIL sat_low got red=%0d changed=%b want 0/0", red, changed); end
        cw = 1; tick(MAXV); cw = 0;
        checks++; if (red !== W'(MAXV)) begin errors++; $display("FAIL back_to_back got red=%0d want %0d", red, MAXV); end
        tick();
        cw = 1; tick(); cw = 0;
        checks++; if (red !== W'(MAXV) || changed !== 1'b0) begin errors++; $display("FAIL sat_high got red=%0d changed=%b want %0d/0", red, changed, MAXV); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        cw = 1; ccw = 1; tick(); cw = 0; ccw = 0;
        checks++; if (red !== 0 || changed !== 1'b0) begin errors++; $display("FAIL both_pulses got red=%0d changed=%b want 0/0", red, changed); end
        btn = 1; tick(7);
        cw = 1; tick(); cw = 0;
        checks++; if (red !== 1 || sel !== 2'd1 || changed !== 1'b1) begin errors++; $display("FAIL press_detent got red=%0d sel=%0d changed=%b want 1/1/1", red, sel, changed); end
        checks++; if (green !== 0) begin errors++; $display("FAIL press_detent_green got %0d want 0", green); end
        btn = 0; tick(10);
    endtask

    task automatic test_accel;
`ifdef KNOB_ACCEL_EN
        int exp[4] = '{1, 9, 17, 16};
`else
        int exp[4] = '{1, 2, 3, 2};
`endif
        int k = 0;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            cw = (c == 0 || c == 5 || c == 10);
            ccw = (c == 12);
            tick();
            if (cw || ccw) begin
                checks++; if (red !== W'(exp[k])) begin errors++; $display("FAIL accel_c%0d got red=%0d want %0d", c, red, exp[k]); end
                k++;
            end
            cw = 0; ccw = 0;
        end
    endtask

    task automatic test_reset_mid_debounce;
        int bad = 0;
        do_reset();
        cw = 1; tick(3); cw = 0;
        btn = 1; tick(2);
        rst = 1; tick(); rst = 0;
        checks++; if (red !== 0 || green !== 0 || blue !== 0 || sel !== 0 || changed !== 0) begin errors++; $display("FAIL mid_reset got red=%0d sel=%0d changed=%b want all 0", red, sel, changed); end
        for (int i = 0; i < 7; i++) begin tick(); if (sel !== 0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_early got %0d bad cycles want 0", bad); end
        tick();
        checks++; if (sel !== 2'd1 || changed !== 1'b1) begin errors++; $display("FAIL mid_reset_press got sel=%0d changed=%b want 1/1", sel, changed); end
        btn = 0; tick(10);
    endtask

    task automatic test_random;
        int r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 7);
            cw = (r == 1 || r == 3 || r == 4);
            ccw = (r == 2 || r == 3 || r == 5);
            if ($urandom_range(0, 11) == 0) btn = ~btn;
            tick();
            checks++; if (red !== W'(m_lv[0]) || green !== W'(m_lv[1]) || blue !== W'(m_lv[2])) begin errors++; $display("FAIL rand_levels@%0d got %0d/%0d/%0d want %0d/%0d/%0d", i, red, green, blue, m_lv[0], m_lv[1], m_lv[2]); end
            checks++; if (sel !== 2'(m_sel)) begin errors++; $display("FAIL rand_sel@%0d got %0d want %0d", i, sel, m_sel); end
            checks++; if (changed !== m_chg) begin errors++; $display("FAIL rand_changed@%0d got %b want %b", i, changed, m_chg); end
        end
        cw = 0; ccw = 0; btn = 0;
    endtask

    initial begin
        test_reset();
        test_cw_steps();
        test_button();
        test_saturate();
        test_simultaneous();
        test_accel();
        test_reset_mid_debounce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
